mul_step2_stage: RTL and testbench

- Second stage of the three-step single-precision multiply pipeline. It registers the step-1 outputs (signs, raw exponents, 26-bit fraction product and carry).
- Computes the result sign and the biased exponent sum, and normalizes the significand by one position on carry. Flags exponent overflow and underflow.
- Carries a valid/ready handshake with a 2-entry skid buffer, so stall back-pressure from step 3 never creates a combinational ready path back to step 1.

---
 rtl/fpu_mul_pkg.sv | 35 +++
 rtl/fpu_skid_buf.sv | 93 +++++++++
 rtl/mul_step2_stage.sv | 152 +++++++++++++++
 tb/tb_mul_step2_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_mul_pkg.sv
// ---------------------------------------------------------------------------
// fpu_mul_pkg
//   Shared constants and payload types for the single-precision multiply
//   pipeline.
//
//   BIAS     : IEEE-754 single exponent bias
//   EXP_MAX  : all-ones biased exponent (Inf/NaN encoding, overflow limit)
//   EXP_W    : default width of the signed internal exponent sum
//   mul2_data_t : step-2 result record at the default exponent width, as
//                 consumed by step 3.
//
//   Optional feature macro: MUL_STEP2_SPECIAL_EN adds the zero/inf/nan
//   operand-class flags to the payload.
// ---------------------------------------------------------------------------
package fpu_mul_pkg;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam int EXP_W   = 10;

    typedef struct packed {
        logic                    sign;
        logic signed [EXP_W-1:0] exp;
        logic [25:0]             frac;
        logic                    sticky;
        logic                    ovf;
        logic                    unf;
`ifdef MUL_STEP2_SPECIAL_EN
        logic                    zero;
        logic                    inf;
        logic                    nan;
`endif
    } mul2_data_t;

endpackage

// File: rtl/fpu_skid_buf.sv
// ---------------------------------------------------------------------------
// fpu_skid_buf
//   Generic 2-entry valid/ready skid buffer. The upstream ready is a
//   register, so downstream stalls never form a combinational path from
//   ready_in to ready_out.
//
//   Parameter:
//     T          payload type
//   Ports:
//     clk        clock
//     rst        synchronous active-high reset (empties the buffer)
//     valid_in   upstream data valid
//     ready_out  buffer can accept (registered)
//     data_in    upstream payload
//     valid_out  payload valid toward downstream
//     ready_in   downstream accepts this cycle
//     data_out   oldest accepted payload
//
//   States:
//     EMPTY : nothing held
//     ONE   : main register holds the head entry
//     FULL  : main holds the head, skid holds the next entry
// ---------------------------------------------------------------------------
module fpu_skid_buf #(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_in,
    output logic ready_out,
    input  T     data_in,
    output logic valid_out,
    input  logic ready_in,
    output T     data_out
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       ready_r;
    T           main_r;
    T           skid_r;
    logic       in_fire;
    logic       out_fire;

    assign in_fire   = valid_in && ready_r;
    assign out_fire  = (state != ST_EMPTY) && ready_in;
    assign ready_out = ready_r;
    assign valid_out = (state != ST_EMPTY);
    assign data_out  = main_r;

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (in_fire) state_next = ST_ONE;
            ST_ONE: begin
                if (in_fire && !out_fire)      state_next = ST_FULL;
                else if (!in_fire && out_fire) state_next = ST_EMPTY;
            end
            ST_FULL:  if (out_fire) state_next = ST_ONE;
            default:  state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_EMPTY;
            // Held low while in reset so nothing is accepted until the
            // cycle after rst deasserts.
            ready_r <= 1'b0;
            main_r  <= '0;
            skid_r  <= '0;
        end else begin
            state   <= state_next;
            ready_r <= (state_next != ST_FULL);
            case (state)
                ST_EMPTY: if (in_fire) main_r <= data_in;
                ST_ONE: begin
                    // Head leaving: new entry becomes the head. Head stalled:
                    // new entry parks behind it in the skid register.
                    if (in_fire && out_fire) main_r <= data_in;
                    else if (in_fire)        skid_r <= data_in;
                end
                ST_FULL:  if (out_fire) main_r <= skid_r;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mul_step2_stage.sv
// ---------------------------------------------------------------------------
// mul_step2_stage
//   Second step of the three-step single-precision multiply pipeline.
//   Combines the operand signs, forms the biased exponent sum, normalizes
//   the 26-bit fraction product by one place on carry and flags exponent
//   overflow/underflow. Results pass through a 2-entry skid buffer so step-3
//   back-pressure never reaches step 1 combinationally.
//
//   Parameters:
//     BIAS       exponent bias subtracted from the sum (127)
//     EXP_W      signed width of the exponent sum (>= 10)
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     valid_in/ready_out  step-1 handshake (ready_out is registered)
//     sign1, sign2      operand signs
//     exp1, exp2        operand biased exponents
//     product, carry_out  step-1 fraction product and its >= 2.0 carry
//     valid_out/ready_in  step-3 handshake
//     sign_out          result sign
//     exp_out           signed exponent sum (not truncated to 8 bits)
//     frac_out          normalized significand, bit 25 = hidden one
//     sticky_out        bit lost by normalization
//     ovf, unf          exp_out >= 255, exp_out <= 0
//   Optional feature macro MUL_STEP2_SPECIAL_EN adds:
//     zero_out          an operand exponent is 0
//     inf_out           an operand exponent is 255 and no operand is zero
//     nan_out           zero operand combined with an exponent-255 operand
// ---------------------------------------------------------------------------
module mul_step2_stage #(
    parameter int BIAS  = 127,
    parameter int EXP_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic             sign1,
    input  logic             sign2,
    input  logic [7:0]       exp1,
    input  logic [7:0]       exp2,
    input  logic [25:0]      product,
    input  logic             carry_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             sign_out,
    output logic [EXP_W-1:0] exp_out,
    output logic [25:0]      frac_out,
    output logic             sticky_out,
`ifdef MUL_STEP2_SPECIAL_EN
    output logic             zero_out,
    output logic             inf_out,
    output logic             nan_out,
`endif
    output logic             ovf,
    output logic             unf
);

    import fpu_mul_pkg::*;

    // Local record at this instance's exponent width; same layout as
    // fpu_mul_pkg::mul2_data_t.
    typedef struct packed {
        logic                    sign;
        logic signed [EXP_W-1:0] exp;
        logic [25:0]             frac;
        logic                    sticky;
        logic                    ovf;
        logic                    unf;
`ifdef MUL_STEP2_SPECIAL_EN
        logic                    zero;
        logic                    inf;
        logic                    nan;
`endif
    } payload_t;

    // Exponent sum in EXP_W-bit two's complement; operands are zero-extended.
    function automatic logic signed [EXP_W-1:0] exp_sum(
        input logic [7:0] e1,
        input logic [7:0] e2,
        input logic       c
    );
        exp_sum = $signed(EXP_W'(e1) + EXP_W'(e2) + EXP_W'(c) - EXP_W'(BIAS));
    endfunction

    function automatic logic exp_over(input logic signed [EXP_W-1:0] e);
        exp_over = (e >= $signed(EXP_W'(EXP_MAX)));
    endfunction

    function automatic logic exp_under(input logic signed [EXP_W-1:0] e);
        exp_under = (e <= $signed(EXP_W'(0)));
    endfunction

    payload_t payload_p0;
    payload_t payload_p1;
    logic     vld_p1;

    // ---- p0: combinational datapath on the input side ----
    always_comb begin
        payload_p0      = '0;
        payload_p0.sign = sign1 ^ sign2;
        payload_p0.exp  = exp_sum(exp1, exp2, carry_out);
        if (carry_out) begin
            payload_p0.frac   = {1'b1, product[25:1]};
            payload_p0.sticky = product[0];
        end else begin
            payload_p0.frac   = product;
            payload_p0.sticky = 1'b0;
        end
        payload_p0.ovf = exp_over(payload_p0.exp);
        payload_p0.unf = exp_under(payload_p0.exp);
`ifdef MUL_STEP2_SPECIAL_EN
        payload_p0.zero = (exp1 == 8'd0) || (exp2 == 8'd0);
        payload_p0.inf  = ((exp1 == 8'(EXP_MAX)) || (exp2 == 8'(EXP_MAX)))
                          && !payload_p0.zero;
        payload_p0.nan  = ((exp1 == 8'(EXP_MAX)) || (exp2 == 8'(EXP_MAX)))
                          && payload_p0.zero;
        // A zero operand makes the exponent sum meaningless.
        if (payload_p0.zero) begin
            payload_p0.ovf = 1'b0;
            payload_p0.unf = 1'b0;
        end
`endif
    end

    // ---- p1: skid-buffered result registers ----
    fpu_skid_buf #(
        .T(payload_t)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_in   (payload_p0),
        .valid_out (vld_p1),
        .ready_in  (ready_in),
        .data_out  (payload_p1)
    );

    assign valid_out  = vld_p1;
    assign sign_out   = payload_p1.sign;
    assign exp_out    = payload_p1.exp;
    assign frac_out   = payload_p1.frac;
    assign sticky_out = payload_p1.sticky;
    assign ovf        = payload_p1.ovf;
    assign unf        = payload_p1.unf;
`ifdef MUL_STEP2_SPECIAL_EN
    assign zero_out   = payload_p1.zero;
    assign inf_out    = payload_p1.inf;
    assign nan_out    = payload_p1.nan;
`endif

endmodule

// File: tb/tb_mul_step2_stage.sv
module tb_mul_step2_stage;

    localparam int EXP_W = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid_in = 1'b0;
    logic             ready_out;
    logic             sign1 = 1'b0, sign2 = 1'b0;
    logic [7:0]       exp1 = '0, exp2 = '0;
    logic [25:0]      product = '0;
    logic             carry_out = 1'b0;
    logic             valid_out;
    logic             ready_in = 1'b1;
    logic             sign_out;
    logic [EXP_W-1:0] exp_out;
    logic [25:0]      frac_out;
    logic             sticky_out;
    logic             ovf, unf;
`ifdef MUL_STEP2_SPECIAL_EN
    logic             zero_out, inf_out, nan_out;
`endif

    always #5 clk = ~clk;

    mul_step2_stage #(.BIAS(127), .EXP_W(EXP_W)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
        .sign1(sign1), .sign2(sign2), .exp1(exp1), .exp2(exp2),
        .product(product), .carry_out(carry_out),
        .valid_out(valid_out), .ready_in(ready_in),
        .sign_out(sign_out), .exp_out(exp_out), .frac_out(frac_out),
        .sticky_out(sticky_out),
`ifdef MUL_STEP2_SPECIAL_EN
        .zero_out(zero_out), .inf_out(inf_out), .nan_out(nan_out),
`endif
        .ovf(ovf), .unf(unf)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference result, computed from the arithmetic meaning of the fields.
    typedef struct {
        int sign;
        int e;
        int frac;
        int sticky;
        int ovf;
        int unf;
        int zero;
        int inf;
        int nan;
    } exp_t;

    function automatic exp_t model(input logic s1, input logic s2, input logic [7:0] e1,
                                   input logic [7:0] e2, input logic [25:0] p, input logic c);
        exp_t r;
        r.sign   = (s1 != s2) ? 1 : 0;
        r.e      = int'(e1) + int'(e2) + int'(c) - 127;
        r.frac   = c ? ((int'(p) / 2) + (1 << 25)) : int'(p);
        r.sticky = c ? (int'(p) % 2) : 0;
        r.ovf    = (r.e >= 255) ? 1 : 0;
        r.unf    = (r.e <= 0) ? 1 : 0;
        r.zero   = (e1 == 0 || e2 == 0) ? 1 : 0;
        r.inf    = ((e1 == 255 || e2 == 255) && r.zero == 0) ? 1 : 0;
        r.nan    = ((e1 == 255 || e2 == 255) && r.zero == 1) ? 1 : 0;
`ifdef MUL_STEP2_SPECIAL_EN
        if (r.zero == 1) begin
            r.ovf = 0;
            r.unf = 0;
        end
`endif
        return r;
    endfunction

    exp_t q[$];
    int   out_log[$];
    logic in_rst  = 1'b1;
    logic started = 1'b0;

    // Bookkeeping at the active edge: values read here are pre-edge.
    always @(posedge clk) begin
        started <= 1'b1;
        in_rst  <= rst;
        if (rst) begin
            q.delete();
        end else begin
            if (valid_out && ready_in) begin
                out_log.push_back(int'(frac_out));
                if (q.size() > 0) void'(q.pop_front());
            end
            if (valid_in && ready_out)
                q.push_back(model(sign1, sign2, exp1, exp2, product, carry_out));
        end
    end

    // Compare process: every cycle, on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            if (in_rst) begin
                chk("rst_valid", valid_out, 0);
                chk("rst_ready", ready_out, 0);
                chk("rst_data", {sign_out, exp_out, frac_out, sticky_out, ovf, unf}, 0);
            end else begin
                chk("m_ready", ready_out, (q.size() < 2) ? 1 : 0);
                chk("m_valid", valid_out, (q.size() > 0) ? 1 : 0);
                if (valid_out && q.size() > 0) begin
                    chk("m_sign", sign_out, q[0].sign);
                    chk("m_exp", $signed(exp_out), q[0].e);
                    chk("m_frac", frac_out, q[0].frac);
                    chk("m_sticky", sticky_out, q[0].sticky);
                    chk("m_ovf", ovf, q[0].ovf);
                    chk("m_unf", unf, q[0].unf);
`ifdef MUL_STEP2_SPECIAL_EN
                    chk("m_zero", zero_out, q[0].zero);
                    chk("m_inf", inf_out, q[0].inf);
                    chk("m_nan", nan_out, q[0].nan);
`endif
                end
            end
        end
    end

    task automatic drive(input logic s1, input logic s2, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [25:0] p, input logic c);
        sign1 = s1; sign2 = s2; exp1 = e1; exp2 = e2; product = p; carry_out = c;
    endtask

    // Offer one transfer and hold it until accepted (bounded).
    task automatic send(input logic s1, input logic s2, input logic [7:0] e1,
                        input logic [7:0] e2, input logic [25:0] p, input logic c);
        int n = 0;
        drive(s1, s2, e1, e2, p, c);
        valid_in = 1'b1;
        while (!ready_out && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 50) chk("send_timeout", 1, 0);
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic directed(input string name, input logic s1, input logic s2,
                            input logic [7:0] e1, input logic [7:0] e2,
                            input logic [25:0] p, input logic c,
                            input int xs, input int xe, input int xf, input int xst,
                            input int xo, input int xu);
        send(s1, s2, e1, e2, p, c);
        @(negedge clk);
        chk({name, "_valid"}, valid_out, 1);
        chk({name, "_sign"}, sign_out, xs);
        chk({name, "_exp"}, $signed(exp_out), xe);
        chk({name, "_frac"}, frac_out, xf);
        chk({name, "_sticky"}, sticky_out, xst);
        chk({name, "_ovf"}, ovf, xo);
        chk({name, "_unf"}, unf, xu);
        #1;
    endtask

    initial begin
        int accepted;
        int cyc;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", ready_out, 1);
        chk("post_rst_valid", valid_out, 0);
        #1;

        ready_in = 1'b1;
        directed("one_x_one", 0, 0, 127, 127, 26'h2000000, 0, 0, 127, 26'h2000000, 0, 0, 0);
        directed("onep5_sq", 0, 0, 127, 127, 26'h0800000, 1, 0, 128, 26'h2400000, 0, 0, 0);
        directed("onep5_stk", 0, 0, 127, 127, 26'h0800001, 1, 0, 128, 26'h2400000, 1, 0, 0);
        directed("sign", 1, 0, 127, 127, 26'h2000000, 0, 1, 127, 26'h2000000, 0, 0, 0);
        directed("ovf", 0, 0, 254, 254, 26'h0000000, 1, 0, 382, 26'h2000000, 0, 1, 0);
        directed("unf", 0, 1, 1, 1, 26'h2000000, 0, 1, -125, 26'h2000000, 0, 0, 1);
        directed("zero_exp", 0, 0, 0, 0, 26'h2000000, 0, 0, -127, 26'h2000000, 0, 0, 1);
        repeat (2) @(negedge clk);
        #1;

        // Back-pressure: A, B accepted, C held off.
        ready_in = 1'b0;
        send(0, 0, 127, 127, 26'h2000001, 0);   // A
        send(0, 0, 127, 127, 26'h2000002, 0);   // B
        drive(0, 0, 127, 127, 26'h2000003, 0);  // C
        valid_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_ready_low", ready_out, 0);
        chk("bp_head_a", frac_out, 26'h2000001);
        #1;
        out_log.delete();
        ready_in = 1'b1;
        cyc = 0;
        while (!ready_out && cyc < 20) begin
            @(negedge clk); #1; cyc++;
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("bp_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            chk("bp_order_a", out_log[0], 26'h2000001);
            chk("bp_order_b", out_log[1], 26'h2000002);
            chk("bp_order_c", out_log[2], 26'h2000003);
        end
        #1;

        // Reset with the buffer full.
        ready_in = 1'b0;
        send(0, 0, 200, 100, 26'h3FFFFFF, 1);
        send(1, 1, 10, 20, 26'h1234567, 0);
        @(negedge clk);
        chk("full_ready", ready_out, 0);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", valid_out, 0);
        chk("mid_rst_frac", frac_out, 0);
        chk("mid_rst_exp", exp_out, 0);
        #1 rst = 1'b0;
        ready_in = 1'b1;
        @(negedge clk);
        chk("after_rst_ready", ready_out, 1);
        chk("after_rst_valid", valid_out, 0);
        #1;

        // Random streaming against the model.
        accepted = 0;
        cyc = 0;
        while (accepted < 1000 && cyc < 20000) begin
            ready_in = ($urandom_range(0, 3) != 0);
            valid_in = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 1), $urandom_range(0, 1),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  26'($urandom), $urandom_range(0, 1));
            if (valid_in && ready_out) accepted++;
            @(negedge clk); #1;
            cyc++;
        end
        if (accepted < 1000) chk("random_timeout", accepted, 1000);
        valid_in = 1'b0;
        ready_in = 1'b1;
        repeat (5) @(negedge clk);
        chk("drain_empty", valid_out, 0);
        chk("drain_model_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
